// File: rtl/ysyx_22041211_dmem_pkg.sv
// ysyx_22041211_dmem_pkg
// Shared definitions for the data-memory responder and its initiator.
//   dmem_state_e   : responder FSM encodings (DMEM_IDLE / DMEM_BUSY / DMEM_RESP)
//   LOAD_MASK_*    : right-aligned byte-lane masks for byte / half / word accesses
//   lane_ok()      : 1 when a 4-bit lane mask is legal at the given byte offset
package ysyx_22041211_dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [7:0] LOAD_MASK_8  = 8'h01;
  localparam logic [7:0] LOAD_MASK_16 = 8'h03;
  localparam logic [7:0] LOAD_MASK_32 = 8'h0F;

  // Mask 0 is a legal no-op; halves need an even offset, words offset 0.
  function automatic logic lane_ok(input logic [3:0] mask, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (mask == 4'b0000)                  ok = 1'b1;
    else if (mask == LOAD_MASK_8[3:0])    ok = 1'b1;
    else if (mask == LOAD_MASK_16[3:0])   ok = ~off[0];
    else if (mask == LOAD_MASK_32[3:0])   ok = (off == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_22041211_dmem_lfsr.sv
// ysyx_22041211_dmem_lfsr
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5, advances every cycle.
// Used only when YSYX_22041211_DMEM_RAND_DELAY_EN is defined.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (loads the seed)
//   lfsr : current register value
module ysyx_22041211_dmem_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

endmodule

// File: rtl/ysyx_22041211_dmem_resp.sv
// ysyx_22041211_dmem_resp
// Sequential data-memory target for the writeback-stage load/store port.
// One request at a time; byte-lane stores / lane-shifted, zero-extended loads
// from an internal word array; fixed access latency, optionally stretched by
// 0..3 random cycles when YSYX_22041211_DMEM_RAND_DELAY_EN is defined.
//
// Handshakes: a transfer on either channel happens on a rising edge where
// valid and ready are both 1. req_ready is 1 only in IDLE outside reset;
// rsp_valid/rsp_rdata/rsp_err stay constant until the rsp handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request channel
//   req_wen                  1 = store, 0 = load
//   req_addr                 byte address
//   req_wdata                right-aligned store data
//   req_mask                 right-aligned byte mask ([3:0] used)
//   rsp_valid/rsp_ready      response channel
//   rsp_rdata                right-aligned load data (0 for stores/errors)
//   rsp_err                  misaligned / illegal mask / out-of-range
//   dbg_state                current FSM state (dmem_state_e encoding)
module ysyx_22041211_dmem_resp #(
  parameter int          DATA_LEN    = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [31:0]         req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [7:0]          req_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          dbg_state
);
  import ysyx_22041211_dmem_pkg::*;

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 8;

  dmem_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    busy_total;
  logic [1:0]          extra;

  logic                lat_wen;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_mask;

  logic                a_wen;
  logic [31:0]         a_addr;
  logic [31:0]         a_wdata;
  logic [3:0]          a_mask;
  logic [1:0]          off;
  logic [31:0]         offs;
  logic                in_range;
  logic                acc_err;
  logic [3:0]          eff_mask;
  logic [31:0]         exp_mask;
  logic [31:0]         wdata_sh;
  logic [31:0]         rdata_sh;
  logic [AW-1:0]       widx;
  logic                commit;

  logic [31:0]         mem [DEPTH_WORDS];

`ifdef YSYX_22041211_DMEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_22041211_dmem_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );
  assign extra = lfsr[1:0];
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign extra = 2'd0;
`endif

  // Cycles spent in BUSY; zero means jump straight from IDLE to RESP.
  assign busy_total = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (req_valid) begin
          if (busy_total == '0) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_BUSY;
            cnt_d   = busy_total - CNT_W'(1);
          end
        end
      end
      DMEM_BUSY: begin
        if (cnt_q == '0) state_d = DMEM_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DMEM_RESP: begin
        if (rsp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
    end else if (state_q == DMEM_IDLE && req_valid) begin
      lat_wen   <= req_wen;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_mask  <= req_mask[3:0];
    end
  end

  // With a one-cycle path the commit edge is the accept edge, so the access
  // must come straight from the request inputs rather than the latch.
  assign a_wen   = (state_q == DMEM_IDLE) ? req_wen       : lat_wen;
  assign a_addr  = (state_q == DMEM_IDLE) ? req_addr      : lat_addr;
  assign a_wdata = (state_q == DMEM_IDLE) ? req_wdata     : lat_wdata;
  assign a_mask  = (state_q == DMEM_IDLE) ? req_mask[3:0] : lat_mask;

  assign off      = a_addr[1:0];
  assign offs     = a_addr - BASE_ADDR;
  assign in_range = (a_addr >= BASE_ADDR) && ({2'b00, offs[31:2]} < 32'(DEPTH_WORDS));
  assign acc_err  = !in_range || !lane_ok(a_mask, off);
  assign widx     = offs[AW+1:2];
  assign eff_mask = a_mask << off;
  assign wdata_sh = a_wdata << {off, 3'b000};

  always_comb begin
    exp_mask = '0;
    for (int i = 0; i < 4; i++) exp_mask[8*i +: 8] = {8{eff_mask[i]}};
  end

  assign rdata_sh = (mem[widx] & exp_mask) >> {off, 3'b000};

  // The edge entering RESP is both the store commit and the load sample.
  assign commit = (state_q != DMEM_RESP) && (state_d == DMEM_RESP) && !rst;

  always_ff @(posedge clk) begin
    if (commit && a_wen && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_mask[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (a_wen || acc_err) ? '0 : rdata_sh;
    end else if (state_q == DMEM_RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  assign req_ready = (state_q == DMEM_IDLE) && !rst;
  assign rsp_valid = (state_q == DMEM_RESP);
  assign dbg_state = state_q;

  logic unused_bits;
  assign unused_bits = ^{req_mask[7:4], offs[1:0]};

endmodule

// File: tb/tb_ysyx_22041211_dmem_resp.sv
// tb_ysyx_22041211_dmem_resp
// Directed bench for the data-memory responder (LATENCY=2, DEPTH=1024,
// random-delay macro undefined). Requests push their hand-computed response
// into exp_q; a monitor pops and compares on every response handshake.
module tb_ysyx_22041211_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // {err, rdata}
  logic [32:0] exp_q[$];

  ysyx_22041211_dmem_resp #(
    .DATA_LEN    (32),
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h8000_0000),
    .LATENCY     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_err, rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
      end
    end
  end

  // ---------------- driver ----------------
  // Starts and ends #1 after a rising edge. hold>0 keeps rsp_ready low for
  // that many cycles once the response is up.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] mask, input logic err, input logic [31:0] rdata,
                        input int hold);
    int guard;
    exp_q.push_back({err, rdata});
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("req_ready_timeout", 64'd0, 64'd1);
    if (hold > 0) rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_mask  = mask;
    @(posedge clk); #1;                       // accept edge T
    req_valid = 1'b0;
    chk("busy_no_valid", {63'd0, rsp_valid}, 64'd0);
    chk("busy_not_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;                       // RESP from cycle T+2
    chk("latency_valid", {63'd0, rsp_valid}, 64'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
        chk("hold_data", {31'd0, rsp_err, rsp_rdata}, {31'd0, err, rdata});
        chk("hold_not_ready", {63'd0, req_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;                       // handshake edge R
    chk("post_hs_ready", {63'd0, req_ready}, 64'd1);
    chk("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
    rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;

    // word store / load
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h0F, 1'b0, 32'hDEAD_BEEF, 0);
    // byte store into lane 3, then word and byte loads
    do_req(1'b1, 32'h8000_0013, 32'h0000_00AA, 8'h01, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h0F, 1'b0, 32'hAAAD_BEEF, 0);
    do_req(1'b0, 32'h8000_0013, 32'h0,         8'h01, 1'b0, 32'h0000_00AA, 0);
    // half store into upper half, half load back
    do_req(1'b1, 32'h8000_0012, 32'h0000_5566, 8'h03, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h8000_0012, 32'h0,         8'h03, 1'b0, 32'h0000_5566, 0);
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h0F, 1'b0, 32'h5566_BEEF, 0);
    // errors: misaligned half, misaligned word, illegal mask, below base
    do_req(1'b0, 32'h8000_0011, 32'h0,         8'h03, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h8000_0012, 32'h0,         8'h0F, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h05, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0,         8'h0F, 1'b1, 32'h0, 0);
    // out-of-range store must not alias onto word 0
    do_req(1'b1, 32'h8000_0000, 32'h1122_3344, 8'h0F, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h8000_0000, 32'h0,         8'h0F, 1'b0, 32'h1122_3344, 0);
    // mask 0 no-op
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h00, 1'b0, 32'h0, 0);
    // backpressure: response held 5 cycles
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h0F, 1'b0, 32'h5566_BEEF, 5);

    // reset during BUSY of a store: no commit, no response
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h0BAD_F00D;
    req_mask  = 8'h0F;
    @(posedge clk); #1;                       // accepted, now BUSY
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;                       // would-be commit edge under reset
    chk("abort_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_rst_ready", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0,         8'h0F, 1'b0, 32'h5566_BEEF, 0);

    repeat (3) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
